// File: rtl/kbdmus_loader_pkg.sv
// Shared definitions for the keyboard/mouse byte-stream loader: command codes,
// FSM state encoding and frame geometry.
package kbdmus_loader_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned KBD_BYTES = 5;
  localparam int unsigned KBD_W     = KBD_BYTES * BYTE_W;
  localparam int unsigned CNT_W     = 3;

  localparam logic [BYTE_W-1:0] CMD_KBD_DEF    = 8'h10;
  localparam logic [BYTE_W-1:0] CMD_MUSX_DEF   = 8'h20;
  localparam logic [BYTE_W-1:0] CMD_MUSY_DEF   = 8'h21;
  localparam logic [BYTE_W-1:0] CMD_MUSBTN_DEF = 8'h22;
  localparam logic [BYTE_W-1:0] CMD_KJ_DEF     = 8'h23;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_KBD     = 3'd2,
    ST_SINGLE  = 3'd3,
    ST_DISCARD = 3'd4
  } state_e;

  // Destination of a single-byte frame, latched from the command byte.
  typedef enum logic [1:0] {
    TGT_MUSX   = 2'd0,
    TGT_MUSY   = 2'd1,
    TGT_MUSBTN = 2'd2,
    TGT_KJ     = 2'd3
  } target_e;

endpackage

// File: rtl/kbdmus_loader_if.sv
// Byte-stream input and holding-register load outputs of the loader.
interface kbdmus_loader_if;
  import kbdmus_loader_pkg::*;

  logic              spi_sel;
  logic [BYTE_W-1:0] byte_in;
  logic              byte_stb;
  logic [KBD_W-1:0]  kbd_out;
  logic              kbd_stb;
  logic [BYTE_W-1:0] mus_out;
  logic              mus_xstb;
  logic              mus_ystb;
  logic              mus_btnstb;
  logic              kj_stb;
  logic              frame_err;

  modport master (
    output spi_sel, byte_in, byte_stb,
    input  kbd_out, kbd_stb, mus_out, mus_xstb, mus_ystb, mus_btnstb, kj_stb, frame_err
  );

  modport slave (
    input  spi_sel, byte_in, byte_stb,
    output kbd_out, kbd_stb, mus_out, mus_xstb, mus_ystb, mus_btnstb, kj_stb, frame_err
  );

endinterface

// File: rtl/kbdmus_loader.sv
// Decodes SPI frames (command byte + data bytes) into registered keyboard,
// mouse and joystick load strobes; keyboard matrix updates are all-or-nothing.
module kbdmus_loader
  import kbdmus_loader_pkg::*;
#(
  parameter logic [BYTE_W-1:0] CMD_KBD    = CMD_KBD_DEF,
  parameter logic [BYTE_W-1:0] CMD_MUSX   = CMD_MUSX_DEF,
  parameter logic [BYTE_W-1:0] CMD_MUSY   = CMD_MUSY_DEF,
  parameter logic [BYTE_W-1:0] CMD_MUSBTN = CMD_MUSBTN_DEF,
  parameter logic [BYTE_W-1:0] CMD_KJ     = CMD_KJ_DEF
) (
  input  logic            fclk,
  input  logic            rst,
  kbdmus_loader_if.slave  bus
);

  state_e            state_q,      state_d;
  target_e           tgt_q,        tgt_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [KBD_W-1:0]  shift_q,      shift_d;
  logic [KBD_W-1:0]  kbd_out_q,    kbd_out_d;
  logic [BYTE_W-1:0] mus_out_q,    mus_out_d;
  logic              kbd_stb_q,    kbd_stb_d;
  logic              mus_xstb_q,   mus_xstb_d;
  logic              mus_ystb_q,   mus_ystb_d;
  logic              mus_btnstb_q, mus_btnstb_d;
  logic              kj_stb_q,     kj_stb_d;
  logic              frame_err_q,  frame_err_d;

  logic              byte_ok;
  logic [KBD_W-1:0]  shift_next;

  assign byte_ok    = bus.spi_sel & bus.byte_stb;
  assign shift_next = {shift_q[KBD_W-BYTE_W-1:0], bus.byte_in};

  // Next-state, datapath and strobe generation; strobes default low so each lasts one cycle.
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    kbd_out_d    = kbd_out_q;
    mus_out_d    = mus_out_q;
    kbd_stb_d    = 1'b0;
    mus_xstb_d   = 1'b0;
    mus_ystb_d   = 1'b0;
    mus_btnstb_d = 1'b0;
    kj_stb_d     = 1'b0;
    frame_err_d  = 1'b0;

    if (!bus.spi_sel) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      shift_d = '0;
      // A command was accepted but its data never completed.
      if (state_q == ST_KBD || state_q == ST_SINGLE) frame_err_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_CMD;

        ST_CMD: begin
          if (byte_ok) begin
            if (bus.byte_in == CMD_KBD) begin
              state_d = ST_KBD;
              cnt_d   = '0;
            end else if (bus.byte_in == CMD_MUSX) begin
              state_d = ST_SINGLE;
              tgt_d   = TGT_MUSX;
            end else if (bus.byte_in == CMD_MUSY) begin
              state_d = ST_SINGLE;
              tgt_d   = TGT_MUSY;
            end else if (bus.byte_in == CMD_MUSBTN) begin
              state_d = ST_SINGLE;
              tgt_d   = TGT_MUSBTN;
            end else if (bus.byte_in == CMD_KJ) begin
              state_d = ST_SINGLE;
              tgt_d   = TGT_KJ;
            end else begin
              state_d     = ST_DISCARD;
              frame_err_d = 1'b1;
            end
          end
        end

        ST_KBD: begin
          if (byte_ok) begin
            shift_d = shift_next;
            if (cnt_q == CNT_W'(KBD_BYTES - 1)) begin
              kbd_out_d = shift_next;
              kbd_stb_d = 1'b1;
              cnt_d     = '0;
              state_d   = ST_DISCARD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end

        ST_SINGLE: begin
          if (byte_ok) begin
            mus_out_d = bus.byte_in;
            state_d   = ST_DISCARD;
            unique case (tgt_q)
              TGT_MUSX:   mus_xstb_d   = 1'b1;
              TGT_MUSY:   mus_ystb_d   = 1'b1;
              TGT_MUSBTN: mus_btnstb_d = 1'b1;
              TGT_KJ:     kj_stb_d     = 1'b1;
              default:    mus_xstb_d   = 1'b0;
            endcase
          end
        end

        ST_DISCARD: state_d = ST_DISCARD;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tgt_q        <= TGT_MUSX;
      cnt_q        <= '0;
      shift_q      <= '0;
      kbd_out_q    <= '0;
      mus_out_q    <= '0;
      kbd_stb_q    <= 1'b0;
      mus_xstb_q   <= 1'b0;
      mus_ystb_q   <= 1'b0;
      mus_btnstb_q <= 1'b0;
      kj_stb_q     <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      kbd_out_q    <= kbd_out_d;
      mus_out_q    <= mus_out_d;
      kbd_stb_q    <= kbd_stb_d;
      mus_xstb_q   <= mus_xstb_d;
      mus_ystb_q   <= mus_ystb_d;
      mus_btnstb_q <= mus_btnstb_d;
      kj_stb_q     <= kj_stb_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.kbd_out    = kbd_out_q;
  assign bus.kbd_stb    = kbd_stb_q;
  assign bus.mus_out    = mus_out_q;
  assign bus.mus_xstb   = mus_xstb_q;
  assign bus.mus_ystb   = mus_ystb_q;
  assign bus.mus_btnstb = mus_btnstb_q;
  assign bus.kj_stb     = kj_stb_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_kbdmus_loader.sv
// Directed-vector bench for kbdmus_loader: frame sequences with hand-computed
// expected strobes and data.
module tb_kbdmus_loader;

  logic fclk = 1'b0;
  logic rst  = 1'b1;

  kbdmus_loader_if bus();

  kbdmus_loader dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 fclk = ~fclk;

  int total = 0;
  int bad   = 0;

  int n_kbd = 0, n_x = 0, n_y = 0, n_btn = 0, n_kj = 0, n_err = 0, n_multi = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe/error event counters, sampled mid-cycle.
  always @(negedge fclk) begin
    if (!rst) begin
      if (bus.kbd_stb)    n_kbd++;
      if (bus.mus_xstb)   n_x++;
      if (bus.mus_ystb)   n_y++;
      if (bus.mus_btnstb) n_btn++;
      if (bus.kj_stb)     n_kj++;
      if (bus.frame_err)  n_err++;
      if ((32'(bus.kbd_stb) + 32'(bus.mus_xstb) + 32'(bus.mus_ystb) +
           32'(bus.mus_btnstb) + 32'(bus.kj_stb)) > 32'd1) n_multi++;
    end
  end

  task automatic clr_counts();
    n_kbd = 0; n_x = 0; n_y = 0; n_btn = 0; n_kj = 0; n_err = 0;
  endtask

  // Returns 1 time unit after the edge that sampled the byte, so that edge's outputs are visible.
  task automatic send_byte(input logic [7:0] b);
    @(posedge fclk); #1;
    bus.byte_in  = b;
    bus.byte_stb = 1'b1;
    @(posedge fclk); #1;
    bus.byte_stb = 1'b0;
  endtask

  task automatic start_frame();
    @(posedge fclk); #1;
    bus.spi_sel = 1'b1;
    @(posedge fclk); #1;
  endtask

  task automatic end_frame();
    @(posedge fclk); #1;
    bus.spi_sel = 1'b0;
    repeat (3) @(posedge fclk);
    #1;
  endtask

  logic [7:0] s_cmd [4];
  logic [7:0] s_dat [4];
  logic [3:0] s_sb  [4];

  initial begin
    bus.spi_sel  = 1'b0;
    bus.byte_in  = 8'h00;
    bus.byte_stb = 1'b0;

    s_cmd[0] = 8'h21; s_dat[0] = 8'h7F; s_sb[0] = 4'b0100;
    s_cmd[1] = 8'h20; s_dat[1] = 8'h80; s_sb[1] = 4'b1000;
    s_cmd[2] = 8'h22; s_dat[2] = 8'h05; s_sb[2] = 4'b0010;
    s_cmd[3] = 8'h23; s_dat[3] = 8'h1F; s_sb[3] = 4'b0001;

    // Reset state
    repeat (3) @(posedge fclk);
    #1;
    chk("rst_kbd_out", 64'(bus.kbd_out), 64'h0);
    chk("rst_mus_out", 64'(bus.mus_out), 64'h0);
    chk("rst_strobes", 64'({bus.kbd_stb, bus.mus_xstb, bus.mus_ystb, bus.mus_btnstb, bus.kj_stb}), 64'h0);
    chk("rst_frame_err", 64'(bus.frame_err), 64'h0);
    rst = 1'b0;

    // Keyboard frame
    clr_counts();
    start_frame();
    send_byte(8'h10);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h04);
    send_byte(8'h08);
    chk("kbd_no_early_stb", 64'(bus.kbd_stb), 64'h0);
    send_byte(8'h10);
    chk("kbd_stb_latency", 64'(bus.kbd_stb), 64'h1);
    chk("kbd_out_val", 64'(bus.kbd_out), 64'h0102040810);
    end_frame();
    chk("kbd_stb_count", 64'(n_kbd), 64'd1);
    chk("kbd_frame_err", 64'(n_err), 64'd0);

    // Single-byte frames
    for (int i = 0; i < 4; i++) begin
      clr_counts();
      start_frame();
      send_byte(s_cmd[i]);
      send_byte(s_dat[i]);
      chk($sformatf("single%0d_mus_out", i), 64'(bus.mus_out), 64'(s_dat[i]));
      chk($sformatf("single%0d_strobe", i),
          64'({bus.mus_xstb, bus.mus_ystb, bus.mus_btnstb, bus.kj_stb}), 64'(s_sb[i]));
      end_frame();
      chk($sformatf("single%0d_count", i), 64'(n_kbd + n_x + n_y + n_btn + n_kj), 64'd1);
      chk($sformatf("single%0d_err", i), 64'(n_err), 64'd0);
    end

    // Empty frame is not an error
    clr_counts();
    start_frame();
    end_frame();
    chk("empty_err", 64'(n_err), 64'd0);

    // Aborted keyboard frame
    clr_counts();
    start_frame();
    send_byte(8'h10);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(posedge fclk); #1;
    bus.spi_sel = 1'b0;
    @(posedge fclk); #1;
    chk("abort_err_pulse", 64'(bus.frame_err), 64'h1);
    @(posedge fclk); #1;
    chk("abort_err_done", 64'(bus.frame_err), 64'h0);
    repeat (2) @(posedge fclk);
    #1;
    chk("abort_kbd_keep", 64'(bus.kbd_out), 64'h0102040810);
    chk("abort_no_stb", 64'(n_kbd + n_x + n_y + n_btn + n_kj), 64'd0);
    chk("abort_err_count", 64'(n_err), 64'd1);

    // Unknown command
    clr_counts();
    start_frame();
    send_byte(8'h55);
    chk("unk_err_pulse", 64'(bus.frame_err), 64'h1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    end_frame();
    chk("unk_no_stb", 64'(n_kbd + n_x + n_y + n_btn + n_kj), 64'd0);
    chk("unk_err_count", 64'(n_err), 64'd1);

    // Extra bytes after a completed single-byte frame, then a byte with sel low
    clr_counts();
    start_frame();
    send_byte(8'h20);
    send_byte(8'h11);
    chk("extra_xstb", 64'(bus.mus_xstb), 64'h1);
    send_byte(8'h22);
    send_byte(8'h33);
    end_frame();
    send_byte(8'h44);
    repeat (2) @(posedge fclk);
    #1;
    chk("extra_mus_out", 64'(bus.mus_out), 64'h11);
    chk("extra_x_count", 64'(n_x), 64'd1);
    chk("extra_total_stb", 64'(n_kbd + n_x + n_y + n_btn + n_kj), 64'd1);
    chk("extra_err", 64'(n_err), 64'd0);

    // Reset mid keyboard frame, then a clean frame
    clr_counts();
    start_frame();
    send_byte(8'h10);
    send_byte(8'h01);
    send_byte(8'h02);
    @(posedge fclk); #1;
    rst = 1'b1;
    @(posedge fclk); #1;
    chk("midrst_kbd_out", 64'(bus.kbd_out), 64'h0);
    chk("midrst_mus_out", 64'(bus.mus_out), 64'h0);
    chk("midrst_outs", 64'({bus.kbd_stb, bus.mus_xstb, bus.mus_ystb, bus.mus_btnstb,
                            bus.kj_stb, bus.frame_err}), 64'h0);
    rst = 1'b0;
    bus.spi_sel = 1'b0;
    repeat (2) @(posedge fclk);
    #1;
    chk("midrst_no_stb", 64'(n_kbd), 64'd0);
    start_frame();
    send_byte(8'h10);
    repeat (4) send_byte(8'hFF);
    send_byte(8'hFF);
    chk("clean_kbd_stb", 64'(bus.kbd_stb), 64'h1);
    chk("clean_kbd_out", 64'(bus.kbd_out), 64'hFFFFFFFFFF);
    end_frame();
    chk("clean_err", 64'(n_err), 64'd0);
    chk("one_hot_strobes", 64'(n_multi), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
